// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI byte arbiter.
package oled_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_FIN,
        HOLD,
        OWNED
    } arb_state_e;

    localparam logic OLED_CMD  = 1'b0;
    localparam logic OLED_DATA = 1'b1;
    localparam int   NREQ_MAX  = 8;
    localparam int   WDT_W     = 12;

endpackage

// File: rtl/oled_spi_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping modulo N, so the previous winner gets lowest priority.
module rr_picker #(
    parameter int N = 3,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o
);

    int cand;

    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        cand     = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = W'(cand);
            end
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares one SpiCtrl byte engine between NREQ OLED byte sources, granting
// per byte round-robin or per burst under lock, with a hang watchdog.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_dc,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              spi_en,
    output logic [7:0]        spi_data,
    input  logic              spi_fin,
    output logic              dc,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);
    // TIMEOUT above 4096 cannot be represented by the 12-bit watchdog
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               WDT_ON   = (TIMEOUT != 0);

    arb_state_e        state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   ack_q;
    logic              err_q;
    logic              spi_en_q;
    logic [7:0]        spi_data_q;
    logic              dc_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     owner_q;
    logic [WDT_W-1:0]  cnt_q;
    logic [WDT_W-1:0]  cnt_d;
    logic              lock_q;
    logic              wdt_expire;

    logic [7:0]        data_arr [NREQ];
    logic              pick_valid;
    logic [NREQ-1:0]   pick_onehot;
    logic [IW-1:0]     pick_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[8*gi +: 8];
    end

    rr_picker #(.N(NREQ)) u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    assign cnt_d      = cnt_q + 1'b1;
    assign wdt_expire = WDT_ON && (cnt_q == WDT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            spi_en_q   <= 1'b0;
            spi_data_q <= 8'h00;
            dc_q       <= OLED_DATA;
            ptr_q      <= IW'(NREQ - 1);
            owner_q    <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_onehot;
                        ptr_q   <= pick_idx;
                        owner_q <= pick_idx;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    spi_data_q <= data_arr[owner_q];
                    dc_q       <= req_dc[owner_q];
                    state_q    <= SEND;
                end
                SEND: begin
                    spi_en_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= WAIT_FIN;
                end
                WAIT_FIN: begin
                    if (spi_fin) begin
                        spi_en_q <= 1'b0;
                        ack_q    <= gnt_q;
                        lock_q   <= lock[owner_q];
                        state_q  <= HOLD;
                    end else if (wdt_expire) begin
                        // aborted bytes never continue a burst
                        spi_en_q <= 1'b0;
                        ack_q    <= gnt_q;
                        err_q    <= 1'b1;
                        lock_q   <= 1'b0;
                        state_q  <= HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (!spi_fin) begin
                        if (lock_q) begin
                            state_q <= OWNED;
                        end else begin
                            gnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                OWNED: begin
                    if (req[owner_q]) begin
                        state_q <= LOAD;
                    end else if (!lock[owner_q]) begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign spi_en   = spi_en_q;
    assign spi_data = spi_data_q;
    assign dc       = dc_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed + randomized bench for oled_spi_arbiter with a behavioural SpiCtrl
// and a round-robin reference model; a second instance exercises the watchdog.
module tb_oled_spi_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst   = 1'b1;
    logic             rst_w = 1'b1;
    logic [N-1:0]     req      = '0;
    logic [N-1:0]     lock     = '0;
    logic [N-1:0]     req_dc   = '0;
    logic [N*8-1:0]   req_data = '0;

    logic [N-1:0] gnt, ack;
    logic         err, spi_en, dc, busy, spi_fin;
    logic [7:0]   spi_data;

    logic [N-1:0] w_gnt, w_ack;
    logic         w_err, w_spi_en, w_dc, w_busy;
    logic [7:0]   w_spi_data;
    logic         w_fin = 1'b0;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = N - 1;

    oled_spi_arbiter #(.NREQ(N), .TIMEOUT(4000)) u_dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .req_data(req_data),
        .req_dc(req_dc), .gnt(gnt), .ack(ack), .err(err), .spi_en(spi_en),
        .spi_data(spi_data), .spi_fin(spi_fin), .dc(dc), .busy(busy)
    );

    oled_spi_arbiter #(.NREQ(N), .TIMEOUT(50)) u_wdt (
        .clk(clk), .rst(rst_w), .req(req), .lock(lock), .req_data(req_data),
        .req_dc(req_dc), .gnt(w_gnt), .ack(w_ack), .err(w_err), .spi_en(w_spi_en),
        .spi_data(w_spi_data), .spi_fin(w_fin), .dc(w_dc), .busy(w_busy)
    );

    // SpiCtrl model: fin 128 clk after spi_en, held until spi_en drops
    int fin_cnt;
    always @(posedge clk) begin
        if (rst || !spi_en) begin
            spi_fin <= 1'b0;
            fin_cnt <= 0;
        end else if (fin_cnt == 127) begin
            spi_fin <= 1'b1;
        end else begin
            fin_cnt <= fin_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_ref(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic dcv);
        req_data[8*i +: 8] = d;
        req_dc[i]          = dcv;
        req[i]             = 1'b1;
    endtask

    task automatic wait_rise_check(input int exp);
        int n;
        n = 0;
        while (spi_en !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check("spi_en_rise_bound", 32'(n < 600), 32'd1);
        check("gnt_owner", 32'(gnt), 32'(1 << exp));
        check("spi_data", 32'(spi_data), 32'(req_data[8*exp +: 8]));
        check("dc", 32'(dc), 32'(req_dc[exp]));
    endtask

    task automatic wait_ack_check(input int exp);
        int n;
        n = 0;
        while (ack === '0 && n < 300) begin
            tick();
            n++;
        end
        check("ack_bound", 32'(n < 300), 32'd1);
        check("ack_owner", 32'(ack), 32'(1 << exp));
        check("err_clear", 32'(err), 32'd0);
        check("spi_en_low_at_ack", 32'(spi_en), 32'd0);
        m_ptr = exp;
    endtask

    task automatic xfer(input int exp);
        wait_rise_check(exp);
        wait_ack_check(exp);
    endtask

    // invariants on the main instance
    logic [7:0]   hd;
    logic         hdc;
    logic         en_prev;
    logic [N-1:0] ack_prev;
    always @(negedge clk) begin
        if (rst) begin
            en_prev  <= 1'b0;
            ack_prev <= '0;
        end else begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (spi_en && en_prev) begin
                check("data_stable", 32'(spi_data), 32'(hd));
                check("dc_stable", 32'(dc), 32'(hdc));
            end
            if (spi_en) check("gnt_during_en", 32'(gnt != '0), 32'd1);
            if (ack != '0) begin
                check("ack_after_en", 32'(en_prev), 32'd1);
                check("ack_not_repeat", 32'(ack_prev), 32'd0);
            end
            en_prev  <= spi_en;
            ack_prev <= ack;
            hd       <= spi_data;
            hdc      <= dc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int o;
        int n;

        // reset state
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_spi_en", 32'(spi_en), 32'd0);
        check("rst_spi_data", 32'(spi_data), 32'h00);
        check("rst_dc", 32'(dc), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single byte, latency
        set_req(0, 8'hAE, 1'b0);
        tick();
        check("t1_gnt_e1", 32'(gnt), 32'b001);
        check("t1_en_e1", 32'(spi_en), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_en_e2", 32'(spi_en), 32'd0);
        check("t1_data_e2", 32'(spi_data), 32'hAE);
        check("t1_dc_e2", 32'(dc), 32'd0);
        tick();
        check("t1_en_e3", 32'(spi_en), 32'd1);
        wait_rise_check(0);
        wait_ack_check(0);
        req = '0;
        tick();
        check("t1_ack_single", 32'(ack), 32'd0);
        repeat (3) tick();
        check("t1_gnt_idle", 32'(gnt), 32'd0);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // 5: reset in WAIT_FIN
        set_req(1, 8'($urandom), 1'($urandom));
        wait_rise_check(rr_ref(req, m_ptr));
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("t5_spi_en", 32'(spi_en), 32'd0);
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_dc", 32'(dc), 32'd1);
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 1'($urandom));
        tick();
        rst   = 1'b0;
        m_ptr = N - 1;

        // 2: contention, grant order 0,1,2,0,1,2
        for (int k = 0; k < 6; k++) begin
            xfer(k % N);
            set_req(k % N, 8'($urandom), 1'($urandom));
        end

        // randomized request patterns against the reference model
        for (int r = 0; r < 10; r++) begin
            o = rr_ref(req, m_ptr);
            xfer(o);
            for (int i = 0; i < N; i++) begin
                if (i == o) begin
                    if ($urandom_range(0, 3) != 0) set_req(i, 8'($urandom), 1'($urandom));
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 8'($urandom), 1'($urandom));
                end
            end
            if (req == '0) set_req(int'($urandom_range(0, N - 1)), 8'($urandom), 1'($urandom));
        end
        req = '0;
        repeat (6) tick();
        check("idle_before_burst", 32'(busy), 32'd0);

        // 3: burst under lock
        set_req(0, 8'($urandom), 1'($urandom));
        xfer(0);
        set_req(0, 8'($urandom), 1'($urandom));
        set_req(2, 8'($urandom), 1'($urandom));
        set_req(1, 8'h22, 1'b0);
        lock = 3'b010;
        xfer(1);
        set_req(1, 8'h00, 1'b1);
        xfer(1);
        set_req(1, 8'h03, 1'b1);
        xfer(1);
        req[1]  = 1'b0;
        lock[1] = 1'b0;
        xfer(rr_ref(req, m_ptr));
        check("t3_after_burst_owner", 32'(m_ptr), 32'd2);
        req = '0;
        repeat (6) tick();

        // 4: watchdog abort on the TIMEOUT=50 instance
        rst = 1'b1;
        tick();
        rst_w = 1'b0;
        lock  = 3'b001;
        set_req(0, 8'h5A, 1'b1);
        n = 0;
        while (w_spi_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t4_rise_bound", 32'(n < 20), 32'd1);
        check("t4_data", 32'(w_spi_data), 32'h5A);
        check("t4_dc", 32'(w_dc), 32'd1);
        n = 0;
        while (w_spi_en === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t4_en_cycles", 32'(n), 32'd50);
        check("t4_ack", 32'(w_ack), 32'b001);
        check("t4_err", 32'(w_err), 32'd1);
        req = '0;
        tick();
        check("t4_ack_pulse", 32'(w_ack), 32'd0);
        check("t4_err_pulse", 32'(w_err), 32'd0);
        check("t4_gnt_idle", 32'(w_gnt), 32'd0);
        check("t4_busy_idle", 32'(w_busy), 32'd0);
        repeat (2) tick();
        check("t4_gnt_stays", 32'(w_gnt), 32'd0);
        lock  = '0;
        rst_w = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
